pong_game_engine: RTL and testbench

- Frame-rate game-state engine for the VGA pong design.
- Owns paddle positions, ball position and direction, serve timing, scores and the win condition.
- Advances once per frame on a single-cycle `frame_tick` from the VGA timing generator. The pixel renderer reads its outputs.
- Parametrised successor to the fixed 640x480 game logic: generic screen, paddle, ball and score sizes, four speed modes, a serve delay and a game-over state.

---
 rtl/pong_game_engine.sv | 235 +++++++++++++++++++++++
 tb/tb_pong_game_engine.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_engine.sv
// Frame-rate game-state engine for the VGA pong design.
// Holds paddle positions, ball position/direction, serve timing, scores and
// the win condition; all game state advances on the single-cycle frame_tick.
module pong_game_engine #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int COORD_W      = 10,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_X_L   = 16,
    parameter int PADDLE_X_R   = 616,
    parameter int PADDLE_STEP  = 4,
    parameter int BALL_SIZE    = 8,
    parameter int SERVE_FRAMES = 60,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               left_up,
    input  logic               left_down,
    input  logic               right_up,
    input  logic               right_down,
    input  logic               score_reset,
    input  logic [1:0]         speed,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic [COORD_W-1:0] paddle_l_y,
    output logic [COORD_W-1:0] paddle_r_y,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic [1:0]         game_state,
    output logic               point_pulse
);

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    typedef logic [COORD_W-1:0] coord_t;
    // One extra bit so sums such as y+step never wrap before comparison.
    typedef logic [COORD_W:0]   ext_t;
    typedef logic [SCORE_W-1:0] score_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_POINT = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam coord_t PAD_RST   = coord_t'((V_ACTIVE - PADDLE_H) / 2);
    localparam coord_t BALL_CX   = coord_t'((H_ACTIVE - BALL_SIZE) / 2);
    localparam coord_t BALL_CY   = coord_t'((V_ACTIVE - BALL_SIZE) / 2);
    localparam ext_t   PAD_MAX   = ext_t'(V_ACTIVE - PADDLE_H);
    localparam ext_t   PAD_STEP  = ext_t'(PADDLE_STEP);
    localparam ext_t   PAD_HGT   = ext_t'(PADDLE_H);
    localparam ext_t   BALL_SZ   = ext_t'(BALL_SIZE);
    localparam ext_t   BALL_XMAX = ext_t'(H_ACTIVE - BALL_SIZE);
    localparam ext_t   BALL_YMAX = ext_t'(V_ACTIVE - BALL_SIZE);
    localparam ext_t   L_FACE    = ext_t'(PADDLE_X_L + PADDLE_W);
    localparam ext_t   R_FACE    = ext_t'(PADDLE_X_R - BALL_SIZE);
    localparam score_t WIN       = score_t'(WIN_SCORE);
    localparam cnt_t   SERVE_END = cnt_t'(SERVE_FRAMES - 1);

    state_t r_state, w_state_nxt;
    coord_t r_pad_l, r_pad_r, r_ball_x, r_ball_y;
    coord_t w_pad_l_nxt, w_pad_r_nxt, w_ball_x_nxt, w_ball_y_nxt;
    logic   r_dir_x, r_dir_y;          // dir_x: 1 = right, dir_y: 1 = down
    logic   w_dir_x_nxt, w_dir_y_nxt;
    score_t r_score_l, r_score_r, w_score_l_nxt, w_score_r_nxt;
    cnt_t   r_serve_cnt, w_serve_cnt_nxt;
    logic   r_point_pulse, w_point_pulse_nxt;

    ext_t   w_step, w_bx, w_by;
    logic   w_ov_l, w_ov_r;

    // Saturating paddle move; both or neither button holds position.
    function automatic coord_t f_paddle(input coord_t y, input logic up, input logic dn);
        ext_t ye;
        ye       = ext_t'(y);
        f_paddle = y;
        if (up && !dn) begin
            f_paddle = (ye < PAD_STEP) ? '0 : coord_t'(ye - PAD_STEP);
        end else if (dn && !up) begin
            f_paddle = (ye + PAD_STEP > PAD_MAX) ? coord_t'(PAD_MAX) : coord_t'(ye + PAD_STEP);
        end
    endfunction

    assign w_step = ext_t'(speed) + ext_t'(1);
    assign w_bx   = ext_t'(r_ball_x);
    assign w_by   = ext_t'(r_ball_y);
    assign w_ov_l = (w_by + BALL_SZ > ext_t'(r_pad_l)) && (w_by < ext_t'(r_pad_l) + PAD_HGT);
    assign w_ov_r = (w_by + BALL_SZ > ext_t'(r_pad_r)) && (w_by < ext_t'(r_pad_r) + PAD_HGT);

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_SERVE;
            r_pad_l       <= PAD_RST;
            r_pad_r       <= PAD_RST;
            r_ball_x      <= BALL_CX;
            r_ball_y      <= BALL_CY;
            r_dir_x       <= 1'b1;
            r_dir_y       <= 1'b1;
            r_score_l     <= '0;
            r_score_r     <= '0;
            r_serve_cnt   <= '0;
            r_point_pulse <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pad_l       <= w_pad_l_nxt;
            r_pad_r       <= w_pad_r_nxt;
            r_ball_x      <= w_ball_x_nxt;
            r_ball_y      <= w_ball_y_nxt;
            r_dir_x       <= w_dir_x_nxt;
            r_dir_y       <= w_dir_y_nxt;
            r_score_l     <= w_score_l_nxt;
            r_score_r     <= w_score_r_nxt;
            r_serve_cnt   <= w_serve_cnt_nxt;
            r_point_pulse <= w_point_pulse_nxt;
        end
    end

    // Next-state logic: score_reset overrides the frame update entirely.
    always_comb begin
        w_state_nxt       = r_state;
        w_pad_l_nxt       = r_pad_l;
        w_pad_r_nxt       = r_pad_r;
        w_ball_x_nxt      = r_ball_x;
        w_ball_y_nxt      = r_ball_y;
        w_dir_x_nxt       = r_dir_x;
        w_dir_y_nxt       = r_dir_y;
        w_score_l_nxt     = r_score_l;
        w_score_r_nxt     = r_score_r;
        w_serve_cnt_nxt   = r_serve_cnt;
        w_point_pulse_nxt = 1'b0;

        if (score_reset) begin
            w_score_l_nxt   = '0;
            w_score_r_nxt   = '0;
            w_serve_cnt_nxt = '0;
            w_ball_x_nxt    = BALL_CX;
            w_ball_y_nxt    = BALL_CY;
            w_state_nxt     = ST_SERVE;
        end else if (frame_tick) begin
            w_pad_l_nxt = f_paddle(r_pad_l, left_up, left_down);
            w_pad_r_nxt = f_paddle(r_pad_r, right_up, right_down);

            case (r_state)
                ST_SERVE: begin
                    w_ball_x_nxt = BALL_CX;
                    w_ball_y_nxt = BALL_CY;
                    if (r_serve_cnt == SERVE_END) begin
                        w_serve_cnt_nxt = '0;
                        w_state_nxt     = ST_PLAY;
                    end else begin
                        w_serve_cnt_nxt = r_serve_cnt + cnt_t'(1);
                    end
                end

                ST_PLAY: begin
                    if (r_dir_y) begin
                        if (w_by + w_step >= BALL_YMAX) begin
                            w_ball_y_nxt = coord_t'(BALL_YMAX);
                            w_dir_y_nxt  = 1'b0;
                        end else begin
                            w_ball_y_nxt = coord_t'(w_by + w_step);
                        end
                    end else begin
                        if (w_by < w_step) begin
                            w_ball_y_nxt = '0;
                            w_dir_y_nxt  = 1'b1;
                        end else begin
                            w_ball_y_nxt = coord_t'(w_by - w_step);
                        end
                    end

                    if (!r_dir_x) begin
                        if (w_bx >= L_FACE && w_bx <= L_FACE + w_step && w_ov_l) begin
                            w_ball_x_nxt = coord_t'(L_FACE);
                            w_dir_x_nxt  = 1'b1;
                        end else if (w_bx < w_step) begin
                            w_score_r_nxt     = r_score_r + score_t'(1);
                            w_point_pulse_nxt = 1'b1;
                            w_state_nxt       = ST_POINT;
                        end else begin
                            w_ball_x_nxt = coord_t'(w_bx - w_step);
                        end
                    end else begin
                        if (w_bx + w_step >= R_FACE && w_bx <= R_FACE && w_ov_r) begin
                            w_ball_x_nxt = coord_t'(R_FACE);
                            w_dir_x_nxt  = 1'b0;
                        end else if (w_bx + w_step > BALL_XMAX) begin
                            w_score_l_nxt     = r_score_l + score_t'(1);
                            w_point_pulse_nxt = 1'b1;
                            w_state_nxt       = ST_POINT;
                        end else begin
                            w_ball_x_nxt = coord_t'(w_bx + w_step);
                        end
                    end
                end

                // dir_x is left as it was on the miss, which already points
                // toward the player who conceded.
                ST_POINT: begin
                    w_ball_x_nxt    = BALL_CX;
                    w_ball_y_nxt    = BALL_CY;
                    w_dir_y_nxt     = ~r_dir_y;
                    w_serve_cnt_nxt = '0;
                    if (r_score_l == WIN || r_score_r == WIN) begin
                        w_state_nxt = ST_OVER;
                    end else begin
                        w_state_nxt = ST_SERVE;
                    end
                end

                ST_OVER: begin
                    w_ball_x_nxt = BALL_CX;
                    w_ball_y_nxt = BALL_CY;
                end
            endcase
        end
    end

    assign ball_x      = r_ball_x;
    assign ball_y      = r_ball_y;
    assign paddle_l_y  = r_pad_l;
    assign paddle_r_y  = r_pad_r;
    assign score_l     = r_score_l;
    assign score_r     = r_score_r;
    assign game_state  = r_state;
    assign point_pulse = r_point_pulse;

endmodule

// File: tb/tb_pong_game_engine.sv
// Directed bench for pong_game_engine: reset, paddle saturation, serve
// timing, right miss, paddle hits on both sides, win and new game.
module tb_pong_game_engine;

    logic       clk = 1'b0;
    logic       rst, frame_tick, left_up, left_down, right_up, right_down, score_reset;
    logic [1:0] speed;
    logic [9:0] ball_x, ball_y, paddle_l_y, paddle_r_y;
    logic [3:0] score_l, score_r;
    logic [1:0] game_state;
    logic       point_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ticks;

    pong_game_engine dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .left_up     (left_up),
        .left_down   (left_down),
        .right_up    (right_up),
        .right_down  (right_down),
        .score_reset (score_reset),
        .speed       (speed),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .paddle_l_y  (paddle_l_y),
        .paddle_r_y  (paddle_r_y),
        .score_l     (score_l),
        .score_r     (score_r),
        .game_state  (game_state),
        .point_pulse (point_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame tick; returns at the falling edge after the sampling edge.
    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Tick until a point is scored, bounded by budget.
    task automatic run_until_pulse(input int budget, output int n);
        logic seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < budget) begin
            tick();
            n++;
            seen = point_pulse;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pad_l"}, paddle_l_y, 208);
        check({tag, "_pad_r"}, paddle_r_y, 208);
        check({tag, "_ball_x"}, ball_x, 316);
        check({tag, "_ball_y"}, ball_y, 236);
        check({tag, "_score_l"}, score_l, 0);
        check({tag, "_score_r"}, score_r, 0);
        check({tag, "_state"}, game_state, 0);
        check({tag, "_pulse"}, point_pulse, 0);
    endtask

    initial begin
        rst = 1'b0; frame_tick = 1'b0; score_reset = 1'b0; speed = 2'd0;
        left_up = 1'b0; left_down = 1'b0; right_up = 1'b0; right_down = 1'b0;

        do_reset();
        check_reset_state("rst");

        // Paddle saturation at both ends
        left_up = 1'b1; right_down = 1'b1;
        repeat (51) tick();
        check("pad_l_t51", paddle_l_y, 4);
        check("pad_r_t51", paddle_r_y, 412);
        tick();
        check("pad_l_t52", paddle_l_y, 0);
        check("pad_r_t52", paddle_r_y, 416);
        repeat (8) tick();
        check("pad_l_t60", paddle_l_y, 0);
        check("pad_r_t60", paddle_r_y, 416);
        check("state_t60", game_state, 1);
        left_up = 1'b0; right_down = 1'b0; left_down = 1'b1;
        repeat (3) tick();
        check("pad_l_down3", paddle_l_y, 12);
        left_up = 1'b1;
        repeat (2) tick();
        check("pad_l_both", paddle_l_y, 12);
        left_up = 1'b0; left_down = 1'b0;

        // Serve timing, speed 3, right paddle parked at 0
        speed = 2'd3; right_up = 1'b1;
        do_reset();
        repeat (59) tick();
        check("serve59_state", game_state, 0);
        check("serve59_x", ball_x, 316);
        tick();
        check("serve60_state", game_state, 1);
        check("serve60_x", ball_x, 316);
        check("serve60_y", ball_y, 236);
        tick();
        check("play1_x", ball_x, 320);
        check("play1_y", ball_y, 240);

        // Miss on the right
        run_until_pulse(200, n_ticks);
        check("miss_r_ticks", n_ticks, 79);
        check("miss_r_pulse", point_pulse, 1);
        check("miss_r_score_l", score_l, 1);
        check("miss_r_score_r", score_r, 0);
        check("miss_r_state", game_state, 2);
        @(negedge clk);
        check("pulse_one_cycle", point_pulse, 0);
        right_up = 1'b0; right_down = 1'b1;
        tick();
        check("point_state", game_state, 0);
        check("point_x", ball_x, 316);
        check("point_y", ball_y, 236);
        check("point_pad_r", paddle_r_y, 4);

        // Right paddle hit at x=608
        repeat (60) tick();
        check("serve2_state", game_state, 1);
        tick();
        check("serve2_x", ball_x, 320);
        check("serve2_y", ball_y, 240);
        repeat (36) tick();
        right_down = 1'b0;
        check("pad_r_392", paddle_r_y, 392);
        repeat (36) tick();
        check("hit_r_x", ball_x, 608);
        check("hit_r_y", ball_y, 416);
        check("hit_r_state", game_state, 1);
        left_up = 1'b1;
        tick();
        check("after_hit_r_x", ball_x, 604);
        check("after_hit_r_y", ball_y, 412);
        repeat (19) tick();
        left_up = 1'b0;
        check("pad_l_128", paddle_l_y, 128);

        // Left paddle hit at x=24 after a top-wall bounce
        repeat (125) tick();
        check("pre_hit_l_x", ball_x, 28);
        check("pre_hit_l_y", ball_y, 160);
        tick();
        check("hit_l_x", ball_x, 24);
        check("hit_l_y", ball_y, 164);
        tick();
        check("after_hit_l_x", ball_x, 28);
        check("hit_score_l", score_l, 1);
        check("hit_score_r", score_r, 0);
        check("hit_state", game_state, 1);

        // Nine right misses to the win
        right_up = 1'b1;
        do_reset();
        for (int r = 1; r <= 9; r++) begin
            run_until_pulse(400, n_ticks);
            check("rally_ticks", n_ticks, 140);
            check("rally_score_l", score_l, r);
            tick();
            check("rally_state", game_state, (r == 9) ? 3 : 0);
        end
        check("over_x", ball_x, 316);
        check("over_y", ball_y, 236);
        check("over_score_l", score_l, 9);
        check("over_score_r", score_r, 0);
        left_down = 1'b1;
        repeat (2) tick();
        left_down = 1'b0;
        check("over_hold_state", game_state, 3);
        check("over_hold_x", ball_x, 316);
        check("over_hold_score", score_l, 9);
        check("over_pad_l", paddle_l_y, 216);

        // New game without a tick
        @(negedge clk) score_reset = 1'b1;
        @(negedge clk) score_reset = 1'b0;
        check("new_score_l", score_l, 0);
        check("new_score_r", score_r, 0);
        check("new_state", game_state, 0);
        check("new_pad_l", paddle_l_y, 216);
        check("new_pad_r", paddle_r_y, 0);
        check("new_x", ball_x, 316);
        check("new_y", ball_y, 236);

        // Reset during play
        repeat (60) tick();
        check("replay_state", game_state, 1);
        repeat (3) tick();
        check("replay_x", ball_x, 328);
        check("replay_y", ball_y, 248);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check_reset_state("rst_play");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
